// File: rtl/shift_fifo_ctrl_pkg.sv
// Package shared by the shift-chain FIFO controller slice.
// Contents:
//   state_t   - controller FSM state encoding (IDLE / RUN / FLUSH)
//   fsm_next  - next-state rule for the controller FSM
// Optional feature macro used elsewhere in the slice: SHIFT_FIFO_ERR_EN.
package shift_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // FLUSH lasts exactly one cycle and then follows en, like IDLE does.
  // In RUN, flush outranks a drop of en.
  function automatic state_t fsm_next(state_t s, logic en, logic flush);
    state_t n;
    n = s;
    case (s)
      S_IDLE:  n = en ? S_RUN : S_IDLE;
      S_RUN:   n = flush ? S_FLUSH : (en ? S_RUN : S_IDLE);
      S_FLUSH: n = en ? S_RUN : S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_fifo_ctrl_if.sv
// Serial bit handshake bundle for the shift-chain FIFO controller.
// Signals:
//   in_valid / in_bit / in_ready    - producer side (push)
//   out_valid / out_bit / out_ready - consumer side (pop)
// Modports:
//   master - the environment: drives in_valid, in_bit, out_ready
//   slave  - the controller:  drives in_ready, out_valid, out_bit
interface shift_fifo_ctrl_if;

  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_ready;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit
  );

endinterface

// File: rtl/shift_fifo_ctrl_shift_chain.sv
// DEPTH-bit serial shift chain used as FIFO storage.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset (clears the chain)
//   shift_en in   shift one place toward MSB, d enters tap 0
//   clr      in   synchronous clear, wins over shift_en
//   d        in   serial data in
//   q        out  [DEPTH-1:0] all taps
module shift_chain #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             d,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] chain_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
    end else if (clr) begin
      chain_q <= '0;
    end else if (shift_en) begin
      chain_q <= {chain_q[DEPTH-2:0], d};
    end
  end

  assign q = chain_q;

endmodule

// File: rtl/shift_fifo_ctrl.sv
// Controller that turns a DEPTH-bit serial shift chain into a 1-bit FIFO
// with valid/ready on both sides. New bits enter tap 0 and push older bits
// toward the MSB, so the oldest bit always sits at tap pc-1.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   en           0 parks the controller in IDLE with contents retained
//   flush        one-cycle request to discard everything stored
//   bus          shift_fifo_ctrl_if.slave handshake bundle
//   pc           occupancy / read index, 0..DEPTH
//   full, empty  pc==DEPTH, pc==0
//   busy         controller is in its one-cycle FLUSH state
//   ovf_err, udf_err  sticky error flags, present only with SHIFT_FIFO_ERR_EN
// Build option: define SHIFT_FIFO_ERR_EN to add the sticky error flags.
module shift_fifo_ctrl
  import shift_fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PCW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  shift_fifo_ctrl_if.slave   bus,
  output logic [PCW-1:0]     pc,
  output logic               full,
  output logic               empty,
  output logic               busy
`ifdef SHIFT_FIFO_ERR_EN
  ,
  output logic               ovf_err,
  output logic               udf_err
`endif
);

  state_t           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [DEPTH-1:0] chain;
  logic             run;
  logic             push;
  logic             pop;
  logic             out_bit_c;

  assign run   = (state_q == S_RUN);
  assign busy  = (state_q == S_FLUSH);
  assign full  = (pc_q == PCW'(DEPTH));
  assign empty = (pc_q == '0);
  assign pc    = pc_q;

  // A flush request masks both handshakes in the cycle it is raised. At full
  // in_ready stays low even if a pop happens, so there is no push-through.
  assign bus.in_ready  = run && !full  && !flush;
  assign bus.out_valid = run && !empty && !flush;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = fsm_next(state_q, en, flush);
  end

  // Simultaneous push and pop: the chain shifts and the oldest bit moves up
  // one tap, so pc stays put and still indexes the next-oldest bit.
  always_comb begin
    pc_d = pc_q;
    if (busy) begin
      pc_d = '0;
    end else if (push && !pop) begin
      pc_d = pc_q + PCW'(1);
    end else if (pop && !push) begin
      pc_d = pc_q - PCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  shift_chain #(
    .DEPTH (DEPTH)
  ) u_chain (
    .clk      (clk),
    .rst      (rst),
    .shift_en (push),
    .clr      (busy),
    .d        (bus.in_bit),
    .q        (chain)
  );

  // Read mux: pc==k selects tap k-1; pc==0 yields 0. Written as a compare
  // loop so the PCW-wide pc never indexes the chain directly.
  always_comb begin
    out_bit_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pc_q == PCW'(i + 1)) begin
        out_bit_c = chain[i];
      end
    end
  end

  assign bus.out_bit = out_bit_c;

`ifdef SHIFT_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Entering FLUSH clears the flags and wins over a same-cycle set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (run && flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (run && bus.in_valid && full) ovf_d = 1'b1;
      if (run && bus.out_ready && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

  a_pc_range: assert property (@(posedge clk) disable iff (!rst) pc_q <= PCW'(DEPTH));
  a_no_ovf:   assert property (@(posedge clk) disable iff (!rst) !(push && !pop && full));
  a_no_udf:   assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule
